io_stall_fsm: RTL and testbench
===============================

# io_stall_fsm

Parametrised multi-cycle control sequencer for the ConfusedCore HMMM pipeline. It replaces the single-channel IO/flash FSM and sits beside the control decoder. It owns all pipeline stalls, branch flushes, halt, and multi-channel `read`/`write` handshakes, with a per-request timeout. The datapath samples `Stall`, `Flash` and `IOAck` every cycle.

## Interface
Parameters:
- `NCH`, 2: number of IO channels (1..16); `CHW = max(1, $clog2(NCH))`.
- `TO_W`, 8: timeout counter width. A request times out after `2^TO_W - 1` waiting cycles.
- `TO_EN`, 1: 1 enables the timeout; 0 means wait forever.
- `FLASH_CYC`, 1: number of cycles `Flash` is held per taken branch (1..7).

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `InstrValid`  in  1: the decode stage holds a real instruction.
- `Op`  in  4: opcode of the decode-stage instruction.
- `FuncID`  in  4: function field. With `Op==4'h0`: `4'h0` = halt, `4'h1` = read, `4'h2` = write.
- `ChSel`  in  CHW: channel field of the IO instruction. Values `>= NCH` map to channel 0.
- `IOReady`  in  NCH: per-channel ready from the IO subsystem.
- `FlashEnable`  in  1: a branch was taken in execute this cycle.
- `DivBusy`  in  1: the divider is mid-operation.
- `IOReq`  out  NCH: one-hot request to the latched channel.
- `IODir`  out  1: 1 = write, 0 = read; valid while `IOReq != 0`.
- `IOWaiting`  out  1: waiting on IO (drives the board LED).
- `IOAck`  out  1: one-cycle pulse when the IO instruction retires.
- `Flash`  out  1: squash the fetch and decode stages.
- `Stall`  out  1: freeze PC and the decode pipeline register.
- `Halted`  out  1: the core has executed halt.
- `IOTimeout`  out  1: sticky error; the IO request was never answered.

## Operation
- States: RUN, IOWAIT, IOACK, FLUSH, HALT, ERR.
- Registered state:
  - `ch_q` (CHW bits), `dir_q`, `to_cnt` (TO_W bits), `fl_cnt` (3 bits).
- `io_dec = InstrValid & Op==0 & (FuncID==1 | FuncID==2)`; `halt_dec = InstrValid & Op==0 & FuncID==0`.
- RUN, evaluated in priority order:
  1. `FlashEnable`: go to FLUSH, set `fl_cnt=FLASH_CYC-1`. The decode instruction is squashed, so `io_dec`/`halt_dec` are ignored.
  2. `halt_dec`: go to HALT.
  3. `io_dec`: latch `ch_q`, set `dir_q=(FuncID==2)`, clear `to_cnt`, go to IOWAIT.
  4. Otherwise stay in RUN.
- IOWAIT:
  - If `IOReady[ch_q]`, go to IOACK.
  - Else if `TO_EN` and `to_cnt==2^TO_W-2`, go to ERR.
  - Else increment `to_cnt`.
  - Ready wins over timeout in the same cycle.
  - `FlashEnable` is ignored here: execute is frozen, so it cannot legally assert.
- IOACK: one cycle, `IOAck=1`, then back to RUN. A back-to-back IO instruction is decoded in the following RUN cycle.
- FLUSH: `Flash=1`. If `fl_cnt==0` go to RUN, else decrement. `InstrValid` is ignored. A new `FlashEnable` during FLUSH reloads `fl_cnt`.
- HALT, ERR: terminal until `reset`.
- Output equations:
  - `IOReq = (IOWAIT) ? onehot(ch_q) : 0`.
  - `IODir = dir_q`.
  - `IOWaiting = IOWAIT`.
  - `Halted = HALT`.
  - `IOTimeout = ERR`.
- `Stall` is combinational:
  - `DivBusy | HALT | ERR | IOWAIT`,
  - or `RUN & io_dec & !FlashEnable`,
  - or `RUN & halt_dec & !FlashEnable`.
- `Stall` is 0 in IOACK (unless `DivBusy`), so the IO instruction retires that cycle.
- `DivBusy` never changes state. It only ORs into `Stall`.

## Timing
- Reset:
  - While `reset` is high: `Stall=1`, all other outputs 0.
  - Next edge: state RUN, all counters and latches 0.
  - Reset mid-IOWAIT drops `IOReq` in the same cycle `reset` rises, since the outputs are gated by `reset`.
- IO latency:
  - `io_dec` in cycle T gives IOWAIT with `IOReq` high at T+1.
  - `IOReady` seen at T+k gives IOACK and `IOAck` at T+k+1.
  - Minimum is 2 cycles from decode to retire; `Stall` is high for cycles T..T+k.
- Handshake: `IOReq` stays stable until the cycle after `IOReady[ch_q]` is sampled high. `IOReady` of unselected channels is ignored.
- Timeout: with `IOReady` never asserted, ERR is entered `2^TO_W-1` cycles after IOWAIT entry.
- `Flash` is high for exactly `FLASH_CYC` consecutive cycles starting the cycle after `FlashEnable`.
- Simultaneous events:
  - `FlashEnable` with `io_dec`: flush wins and no request is issued.
  - `DivBusy` with `io_dec`: the request is still issued.

## Test plan
- Reset behaviour: hold `reset` 3 cycles with `DivBusy=0` -> `Stall=1` during reset. After release: state RUN, `Stall=0`, `IOReq=0`, `IOTimeout=0`.
- Read on channel 1, `NCH=4`: `io_dec` read with `ChSel=1` at T, `IOReady=4'b0010` at T+3.
  - `IOReq=4'b0010` and `IODir=0` for T+1..T+3.
  - `IOAck` at T+4.
  - `Stall` high for T..T+3 and low at T+4.
- Wrong-channel ready: write with `ChSel=2`, `IOReady=4'b0001` held.
  - Remains in IOWAIT.
  - With `TO_W=4`, `IOTimeout=1` exactly 15 cycles after `IOReq` rises, and it stays set until reset.
- Flush priority: `FlashEnable=1` and a read decode in the same cycle, `FLASH_CYC=2` -> `Flash` high 2 cycles, `IOReq` never asserted, then RUN.
- Halt plus divider: `DivBusy` pulsed 5 cycles in RUN -> `Stall` mirrors it with no state change. Then halt decode -> `Halted=1` and `Stall=1` persist for 50 cycles, and clear on reset.
- Back-to-back IO: write ch0 then read ch1, both with `IOReady` already high -> two `IOAck` pulses 3 cycles apart, with a correct `IODir` for each.

Source files
------------

// File: rtl/io_stall_fsm.sv
// io_stall_fsm: pipeline stall/flush/halt sequencer with multi-channel IO handshake and timeout
// Ports: clk, reset (sync, active-high); decode inputs InstrValid/Op/FuncID/ChSel;
//   IOReady per channel; FlashEnable (branch taken); DivBusy (divider running).
//   Outputs IOReq (one-hot), IODir, IOWaiting, IOAck, Flash, Stall, Halted, IOTimeout.
module io_stall_fsm #(
  parameter int NCH       = 2,
  parameter int TO_W      = 8,
  parameter int TO_EN     = 1,
  parameter int FLASH_CYC = 1,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           InstrValid,
  input  logic [3:0]     Op,
  input  logic [3:0]     FuncID,
  input  logic [CHW-1:0] ChSel,
  input  logic [NCH-1:0] IOReady,
  input  logic           FlashEnable,
  input  logic           DivBusy,
  output logic [NCH-1:0] IOReq,
  output logic           IODir,
  output logic           IOWaiting,
  output logic           IOAck,
  output logic           Flash,
  output logic           Stall,
  output logic           Halted,
  output logic           IOTimeout
);
  typedef enum logic [2:0] {RUN, IOWAIT, IOACK, FLUSH, HALT, ERR} state_t;
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [2:0] FL_INIT = 3'(FLASH_CYC - 1);
  state_t state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic dir_q, dir_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [2:0] fl_cnt_q, fl_cnt_d;
  logic io_dec, halt_dec;
  assign io_dec   = InstrValid && Op == 4'h0 && (FuncID == 4'h1 || FuncID == 4'h2);
  assign halt_dec = InstrValid && Op == 4'h0 && FuncID == 4'h0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      ch_q     <= '0;
      dir_q    <= 1'b0;
      to_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      dir_q    <= dir_d;
      to_cnt_q <= to_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    dir_d    = dir_q;
    to_cnt_d = to_cnt_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      RUN: begin
        if (FlashEnable) begin
          state_d  = FLUSH;
          fl_cnt_d = FL_INIT;
        end else if (halt_dec) begin
          state_d = HALT;
        end else if (io_dec) begin
          state_d  = IOWAIT;
          ch_d     = ({1'b0, ChSel} < (CHW+1)'(NCH)) ? ChSel : '0;
          dir_d    = FuncID == 4'h2;
          to_cnt_d = '0;
        end
      end
      IOWAIT: begin
        if (IOReady[ch_q]) state_d = IOACK;
        else if (TO_EN != 0 && to_cnt_q == TO_LAST) state_d = ERR;
        else to_cnt_d = to_cnt_q + 1'b1;
      end
      IOACK: state_d = RUN;
      FLUSH: begin
        if (FlashEnable) fl_cnt_d = FL_INIT;
        else if (fl_cnt_q == 3'd0) state_d = RUN;
        else fl_cnt_d = fl_cnt_q - 3'd1;
      end
      default: state_d = state_q;
    endcase
  end
  // outputs are forced quiet (Stall held) while reset is asserted
  always_comb begin
    IOReq     = (!reset && state_q == IOWAIT) ? NCH'(1) << ch_q : '0;
    IODir     = !reset && dir_q;
    IOWaiting = !reset && state_q == IOWAIT;
    IOAck     = !reset && state_q == IOACK;
    Flash     = !reset && state_q == FLUSH;
    Halted    = !reset && state_q == HALT;
    IOTimeout = !reset && state_q == ERR;
    Stall     = reset || DivBusy || state_q == HALT || state_q == ERR || state_q == IOWAIT ||
                (state_q == RUN && (io_dec || halt_dec) && !FlashEnable);
  end
endmodule

// File: tb/tb_io_stall_fsm.sv
// tb_io_stall_fsm: directed plus randomized check of io_stall_fsm against a behavioural model
module tb_io_stall_fsm;
  localparam int NCH = 4, TO_W = 4, FC = 2;
  localparam int TO_LIMIT = (1 << TO_W) - 1;
  logic clk = 1'b0;
  logic reset, InstrValid, FlashEnable, DivBusy;
  logic [3:0] Op, FuncID, IOReady, IOReq;
  logic [1:0] ChSel;
  logic IODir, IOWaiting, IOAck, Flash, Stall, Halted, IOTimeout;
  int checks = 0, errors = 0;
  int cyc = 0, last_ack = 0, ack_gap = 0;
  bit m_halt, m_err, m_wait, m_ack, m_dir;
  int m_ch, m_waited, m_flash;
  always #5 clk = ~clk;
  io_stall_fsm #(.NCH(NCH), .TO_W(TO_W), .TO_EN(1), .FLASH_CYC(FC)) dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Op(Op), .FuncID(FuncID),
    .ChSel(ChSel), .IOReady(IOReady), .FlashEnable(FlashEnable), .DivBusy(DivBusy),
    .IOReq(IOReq), .IODir(IODir), .IOWaiting(IOWaiting), .IOAck(IOAck), .Flash(Flash),
    .Stall(Stall), .Halted(Halted), .IOTimeout(IOTimeout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic set_in(input bit r, input bit iv, input int fid, input int cs, input logic [3:0] rdy,
                        input bit fe, input bit div);
    reset = r; InstrValid = iv; Op = 4'h0; FuncID = 4'(fid); ChSel = 2'(cs);
    IOReady = rdy; FlashEnable = fe; DivBusy = div;
  endtask
  task automatic tick();
    bit io, hd, idle;
    #1;
    io   = InstrValid && Op == 0 && (FuncID == 1 || FuncID == 2);
    hd   = InstrValid && Op == 0 && FuncID == 0;
    idle = !(m_halt || m_err || m_wait || m_ack || m_flash > 0);
    if (reset) begin
      check("rst_stall", 32'(Stall), 1);
      check("rst_outs", {IOReq, IODir, IOWaiting, IOAck, Flash, Halted, IOTimeout}, 0);
    end else begin
      check("req", 32'(IOReq), m_wait ? 32'(1) << m_ch : 0);
      check("dir", 32'(IODir), 32'(m_dir));
      check("waiting", 32'(IOWaiting), 32'(m_wait));
      check("ack", 32'(IOAck), 32'(m_ack));
      check("flash", 32'(Flash), 32'(m_flash > 0));
      check("halted", 32'(Halted), 32'(m_halt));
      check("timeout", 32'(IOTimeout), 32'(m_err));
      check("stall", 32'(Stall), 32'(DivBusy || m_halt || m_err || m_wait || (idle && !FlashEnable && (io || hd))));
      if (IOAck) begin
        ack_gap = cyc - last_ack;
        last_ack = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    if (reset) begin
      {m_halt, m_err, m_wait, m_ack, m_dir} = '0;
      m_ch = 0; m_waited = 0; m_flash = 0;
    end else if (m_halt || m_err) begin
    end else if (m_ack) m_ack = 0;
    else if (m_wait) begin
      if (IOReady[m_ch]) begin
        m_wait = 0; m_ack = 1;
      end else if (++m_waited >= TO_LIMIT) begin
        m_wait = 0; m_err = 1;
      end
    end else if (m_flash > 0) m_flash = FlashEnable ? FC : m_flash - 1;
    else if (FlashEnable) m_flash = FC;
    else if (hd) m_halt = 1;
    else if (io) begin
      m_wait = 1; m_waited = 0; m_dir = FuncID == 2;
      m_ch = (int'(ChSel) < NCH) ? int'(ChSel) : 0;
    end
    #1;
  endtask
  initial begin
    int n;
    set_in(1, 0, 0, 0, 4'h0, 0, 0);
    repeat (3) tick();
    set_in(0, 0, 0, 0, 4'h0, 0, 0);
    tick();
    // read on channel 1, ready three cycles later
    set_in(0, 1, 1, 1, 4'h0, 0, 0); tick();
    set_in(0, 0, 0, 0, 4'h0, 0, 0); repeat (2) tick();
    set_in(0, 0, 0, 0, 4'b0010, 0, 0); tick();
    set_in(0, 0, 0, 0, 4'h0, 0, 0); repeat (2) tick();
    // write on channel 2 with only channel 0 ready: times out
    set_in(0, 1, 2, 2, 4'b0001, 0, 0); tick();
    set_in(0, 0, 0, 0, 4'b0001, 0, 0);
    n = 0;
    while (!IOTimeout && n < 40) begin tick(); n++; end
    check("timeout_cycles", n, 15);
    repeat (5) tick();
    set_in(1, 0, 0, 0, 4'h0, 0, 0); tick();
    // branch flush beats a simultaneous read decode
    set_in(0, 1, 1, 3, 4'h0, 1, 0); tick();
    set_in(0, 0, 0, 0, 4'h0, 0, 0);
    n = 0;
    while (Flash && n < 10) begin tick(); n++; end
    check("flash_cycles", n, FC);
    tick();
    // divider pulses then halt
    set_in(0, 0, 0, 0, 4'h0, 0, 1); repeat (5) tick();
    set_in(0, 1, 0, 0, 4'h0, 0, 0); tick();
    set_in(0, 0, 0, 0, 4'h0, 0, 0); repeat (50) tick();
    set_in(1, 0, 0, 0, 4'h0, 0, 0); tick();
    // back-to-back write ch0 then read ch1 with all ready
    set_in(0, 1, 2, 0, 4'hf, 0, 0); tick();
    set_in(0, 0, 0, 0, 4'hf, 0, 0); repeat (2) tick();
    set_in(0, 1, 1, 1, 4'hf, 0, 0); tick();
    set_in(0, 0, 0, 0, 4'hf, 0, 0); repeat (3) tick();
    check("ack_gap", ack_gap, 3);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int fid;
      fid = $urandom_range(0, 3);
      if (fid == 0 && $urandom_range(0, 7) != 0) fid = 1;
      set_in($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, fid, $urandom_range(0, 3),
             4'($urandom), !m_wait && $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      Op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
